// File: rtl/icache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : icache_ctrl
//  Purpose  : Instruction-cache control FSM between the CPU fetch port and
//             the tag/data arrays. Looks up tag, refills a 4-word line from
//             memory on a miss, and sequences cache-wide flushes.
//             Address split: tag=[31:10], index=[9:4], word=[3:2].
//  Options  : ICACHE_PERF_CNT_EN - saturating hit/miss performance counters
//             (ports tied to 0 when undefined).
//  Revision : 1.0 - initial release
// ============================================================================
module icache_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // CPU fetch port
  input  logic                  cpu_req_valid,
  input  logic [31:0]           cpu_req_addr,
  output logic                  cpu_req_ready,
  output logic                  cpu_resp_valid,
  output logic [31:0]           cpu_resp_data,
  input  logic                  flush_req,
  // Tag array
  output logic [5:0]            lookup_index,
  output logic [21:0]           lookup_tag,
  input  logic                  hit,
  output logic                  update_valid,
  output logic [5:0]            update_index,
  output logic [21:0]           update_tag,
  output logic                  flush_all,
  // Data array
  output logic [5:0]            data_rd_index,
  output logic [1:0]            data_rd_word,
  input  logic [31:0]           data_rdata,
  output logic                  data_we,
  output logic [5:0]            data_wr_index,
  output logic [1:0]            data_wr_word,
  output logic [31:0]           data_wdata,
  // Memory line-fill port
  output logic                  mem_req_valid,
  output logic [31:0]           mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  // Performance counters
  output logic [PERF_CNT_W-1:0] perf_hit_cnt,
  output logic [PERF_CNT_W-1:0] perf_miss_cnt
);

  // Index of the final beat of a line; the beat counter is 2 bits wide.
  localparam logic [1:0] c_last_beat = 2'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_MEM_REQ = 3'd2,
    S_REFILL  = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:2] r_addr;        // latched fetch address (byte offset dropped)
  logic [1:0]  r_cnt;         // refill beat counter
  logic        r_flush_pend;  // flush requested, not yet issued
  logic [31:0] r_resp_word;   // requested word captured during refill
  logic        r_resp_arm;    // second RESP cycle: deliver the word

  logic [21:0] w_tag;
  logic [5:0]  w_index;
  logic [1:0]  w_word;
  logic        w_flush_fire;
  logic        w_beat;
  logic        w_unused_addr_lsbs;

  assign w_tag   = r_addr[31:10];
  assign w_index = r_addr[9:4];
  assign w_word  = r_addr[3:2];

  // Byte offset within a word is irrelevant for instruction fetch.
  assign w_unused_addr_lsbs = ^cpu_req_addr[1:0];

  // A flush (new or pending) blocks acceptance; only IDLE accepts.
  assign cpu_req_ready = (r_state == S_IDLE) & ~r_flush_pend & ~flush_req;
  assign w_flush_fire  = (r_state == S_IDLE) & r_flush_pend;
  assign flush_all     = w_flush_fire;
  assign w_beat        = (r_state == S_REFILL) & mem_rvalid;

  // Array addressing always follows the latched request.
  assign lookup_index  = w_index;
  assign lookup_tag    = w_tag;
  assign data_rd_index = w_index;
  assign data_rd_word  = w_word;
  assign data_wr_index = w_index;
  assign data_wr_word  = r_cnt;
  assign data_wdata    = mem_rdata;
  assign update_index  = w_index;
  assign update_tag    = w_tag;
  assign mem_req_addr  = {r_addr[31:4], 4'h0};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and per-state strobes
  always_comb begin
    w_next         = r_state;
    cpu_resp_valid = 1'b0;
    cpu_resp_data  = 32'h0;
    mem_req_valid  = 1'b0;
    data_we        = 1'b0;
    update_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu_req_valid && cpu_req_ready) begin
          w_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (hit) begin
          cpu_resp_valid = 1'b1;
          cpu_resp_data  = data_rdata;
          w_next         = S_IDLE;
        end else begin
          w_next = S_MEM_REQ;
        end
      end
      S_MEM_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          w_next = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_rvalid) begin
          data_we = 1'b1;
          if (r_cnt == c_last_beat) begin
            update_valid = 1'b1;
            w_next       = S_RESP;
          end
        end
      end
      S_RESP: begin
        // First RESP cycle lets the final data/tag writes commit.
        if (r_resp_arm) begin
          cpu_resp_valid = 1'b1;
          cpu_resp_data  = r_resp_word;
          w_next         = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the fetch address on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (cpu_req_valid && cpu_req_ready) begin
      r_addr <= cpu_req_addr[31:2];
    end
  end

  // Beat counter: cleared on the memory handshake, advances per beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 2'd0;
    end else if ((r_state == S_MEM_REQ) && mem_req_ready) begin
      r_cnt <= 2'd0;
    end else if (w_beat) begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  // Capture the requested word as it streams past
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_word <= 32'h0;
    end else if (w_beat && (r_cnt == w_word)) begin
      r_resp_word <= mem_rdata;
    end
  end

  // Two-cycle RESP sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_arm <= 1'b0;
    end else if (r_state == S_RESP) begin
      r_resp_arm <= ~r_resp_arm;
    end else begin
      r_resp_arm <= 1'b0;
    end
  end

  // Pending flush: set from any state, consumed by the IDLE flush pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_pend <= 1'b0;
    end else begin
      r_flush_pend <= flush_req | (r_flush_pend & ~w_flush_fire);
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] r_hit_cnt;
  logic [PERF_CNT_W-1:0] r_miss_cnt;

  // Saturating hit/miss counters updated on the CHECK decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == S_CHECK) begin
      if (hit) begin
        if (r_hit_cnt != {PERF_CNT_W{1'b1}}) begin
          r_hit_cnt <= r_hit_cnt + 1'b1;
        end
      end else begin
        if (r_miss_cnt != {PERF_CNT_W{1'b1}}) begin
          r_miss_cnt <= r_miss_cnt + 1'b1;
        end
      end
    end
  end

  assign perf_hit_cnt  = r_hit_cnt;
  assign perf_miss_cnt = r_miss_cnt;
`else
  assign perf_hit_cnt  = '0;
  assign perf_miss_cnt = '0;
`endif

endmodule
`default_nettype wire
